// File: rtl/cpu_top_boot.sv
// cpu_top_boot: FPGA top shell for a Nexys4-class board.
//   Receives a framed program image over UART 8N1, writes it into an internal
//   instruction memory, answers each frame with one UART byte, latches button
//   interrupt requests and scans status onto the 8-digit seven-segment display.
// Ports:
//   CLK100MHZ, CPU_RESETN        clock, async active-low reset
//   BTNC/U/L/R/D                 interrupt buttons INT1..INT5 (async)
//   UART_TXD_IN / UART_RXD_OUT   serial in from host / serial out to host
//   AN[7:0], CA..CG, DP          display digit enables and segments (active-low)
//   imem_addr / imem_rdata       instruction fetch port for the external core
//   irq_pending                  latched interrupt requests for the core
//   dbg_state, dbg_count         parser state code and loaded word count
//   dbg_rx_state, dbg_tx_busy    UART receiver state and transmitter activity
// Handshakes: rx byte delivery is a one-cycle valid strobe with no ready
// (the parser always accepts); a TX request writes a one-deep queue
// unconditionally, overwriting any byte still waiting there.
module cpu_top_boot #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int IMEM_WORDS = 256,
    parameter int SCAN_BITS  = 17
) (
    input  logic                          CLK100MHZ,
    input  logic                          CPU_RESETN,
    input  logic                          BTNC,
    input  logic                          BTNU,
    input  logic                          BTNL,
    input  logic                          BTNR,
    input  logic                          BTND,
    input  logic                          UART_TXD_IN,
    output logic                          UART_RXD_OUT,
    output logic [7:0]                    AN,
    output logic                          CA,
    output logic                          CB,
    output logic                          CC,
    output logic                          CD,
    output logic                          CE,
    output logic                          CF,
    output logic                          CG,
    output logic                          DP,
    input  logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
    output logic [31:0]                   imem_rdata,
    output logic [4:0]                    irq_pending,
    output logic [3:0]                    dbg_state,
    output logic [15:0]                   dbg_count,
    output logic [2:0]                    dbg_rx_state,
    output logic                          dbg_tx_busy
);
    localparam int          BIT_CYC   = CLK_HZ / BAUD;
    localparam int          AW        = $clog2(IMEM_WORDS);
    localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
    localparam logic [15:0] HALF_LAST = 16'(BIT_CYC / 2 - 1);

    // Encodings double as the display state code.
    typedef enum logic [3:0] {
        P_HUNT = 4'h0, P_STAG = 4'h1, P_SPAD = 4'h2, P_LEN  = 4'h3, P_DATA = 4'h4,
        P_END  = 4'h5, P_ETAG = 4'h6, P_EPAD = 4'h7, P_DONE = 4'hD, P_ERR  = 4'hE
    } p_state_e;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

    logic clk, rst_n;
    assign clk   = CLK100MHZ;
    assign rst_n = CPU_RESETN;

    // ---------------- UART receiver ----------------
    logic        rx_s1_q, rx_s2_q;
    rx_state_e   rx_st_q, rx_st_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_valid_q, rx_valid_d;

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_valid_d = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s2_q) rx_st_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) begin
                    rx_valid_d = 1'b1;
                    rx_st_d    = RX_STOP;
                end
            end
            // Run to the middle of the stop bit before looking for idle-high,
            // so a low stop bit after a high bit 7 is not taken as a start.
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                rx_st_d  = RX_WAIT;
            end
            RX_WAIT: begin
                rx_cnt_d = '0;
                if (rx_s2_q) rx_st_d = RX_IDLE;
            end
            default: rx_st_d = RX_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_st_q    <= RX_WAIT;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_s1_q    <= UART_TXD_IN;
            rx_s2_q    <= rx_s1_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // ---------------- frame parser ----------------
    p_state_e    ps_q, ps_d;
    logic [31:0] sh_q, sh_d, sh_next;
    logic [1:0]  bc_q, bc_d;
    logic [15:0] len_q, len_d;
    logic [15:0] count_q, count_d;
    logic        imem_we, sync_hit, tx_req;
    logic [7:0]  tx_byte;
    logic [31:0] imem_q [IMEM_WORDS];

    always_comb begin
        ps_d     = ps_q;
        sh_d     = sh_q;
        bc_d     = bc_q;
        len_d    = len_q;
        count_d  = count_q;
        imem_we  = 1'b0;
        sync_hit = 1'b0;
        tx_req   = 1'b0;
        tx_byte  = 8'h00;
        sh_next  = {sh_q[23:0], rx_sh_q};
        if (ps_q == P_DONE) begin
            tx_req  = 1'b1;
            tx_byte = count_q[7:0];
            sh_d    = '0;
            ps_d    = P_HUNT;
        end else if (ps_q == P_ERR) begin
            tx_req  = 1'b1;
            tx_byte = 8'hEE;
            sh_d    = '0;
            ps_d    = P_HUNT;
        end else if (rx_valid_q) begin
            bc_d = bc_q + 2'd1;
            case (ps_q)
                P_HUNT: begin
                    sh_d = sh_next;
                    if (sh_next == 32'hF0F0_F0F0) begin
                        sync_hit = 1'b1;
                        count_d  = '0;
                        bc_d     = '0;
                        ps_d     = P_STAG;
                    end
                end
                P_STAG: begin
                    bc_d = '0;
                    ps_d = (rx_sh_q == 8'hC2) ? P_SPAD : P_ERR;
                end
                P_SPAD: if (bc_q == 2'd2) begin
                    bc_d = '0;
                    ps_d = P_LEN;
                end
                P_LEN: begin
                    sh_d = sh_next;
                    if (bc_q == 2'd3) begin
                        len_d = sh_next[15:0];
                        if (sh_next > 32'(IMEM_WORDS)) ps_d = P_ERR;
                        else if (sh_next == 32'd0)     ps_d = P_END;
                        else                           ps_d = P_DATA;
                    end
                end
                P_DATA: begin
                    sh_d = sh_next;
                    if (bc_q == 2'd3) begin
                        imem_we = 1'b1;
                        count_d = count_q + 16'd1;
                        if (count_q + 16'd1 == len_q) ps_d = P_END;
                    end
                end
                P_END: begin
                    sh_d = sh_next;
                    if (bc_q == 2'd3)
                        ps_d = (sh_next == 32'h0F0F_0F0F) ? P_ETAG : P_ERR;
                end
                P_ETAG: begin
                    bc_d = '0;
                    ps_d = (rx_sh_q == 8'hC2) ? P_EPAD : P_ERR;
                end
                P_EPAD: if (bc_q == 2'd2) begin
                    bc_d = '0;
                    ps_d = P_DONE;
                end
                default: ps_d = P_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q    <= P_HUNT;
            sh_q    <= '0;
            bc_q    <= '0;
            len_q   <= '0;
            count_q <= '0;
        end else begin
            ps_q    <= ps_d;
            sh_q    <= sh_d;
            bc_q    <= bc_d;
            len_q   <= len_d;
            count_q <= count_d;
        end
    end

    // Memory has no reset: an image survives a CPU reset.
    always_ff @(posedge clk) begin
        if (imem_we) imem_q[count_q[AW-1:0]] <= sh_next;
    end
    assign imem_rdata = imem_q[imem_addr];

    // ---------------- UART transmitter ----------------
    logic        tx_busy_q, tx_busy_d;
    logic [9:0]  tx_sh_q, tx_sh_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic        tx_pend_q, tx_pend_d;
    logic [7:0]  tx_pdata_q, tx_pdata_d;

    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_pend_d  = tx_pend_q;
        tx_pdata_d = tx_pdata_q;
        if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                tx_bit_d = tx_bit_q + 4'd1;
                if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
            end else begin
                tx_cnt_d = tx_cnt_q + 16'd1;
            end
        end else if (tx_pend_q) begin
            tx_busy_d = 1'b1;
            tx_sh_d   = {1'b1, tx_pdata_q, 1'b0};
            tx_cnt_d  = '0;
            tx_bit_d  = '0;
            tx_pend_d = 1'b0;
        end
        if (tx_req) begin
            tx_pend_d  = 1'b1;
            tx_pdata_d = tx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            tx_sh_q    <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_pend_q  <= 1'b0;
            tx_pdata_q <= '0;
        end else begin
            tx_busy_q  <= tx_busy_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_pend_q  <= tx_pend_d;
            tx_pdata_q <= tx_pdata_d;
        end
    end

    // Shifter refills with ones, so bit 0 is the idle-high line when not busy.
    assign UART_RXD_OUT = tx_sh_q[0];

    // ---------------- interrupt requests ----------------
    logic [4:0] btn_s1_q, btn_s2_q, btn_s3_q, pend_q, pend_d;

    always_comb begin
        pend_d = (sync_hit ? 5'b0 : pend_q) | (btn_s2_q & ~btn_s3_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            btn_s3_q <= '0;
            pend_q   <= '0;
        end else begin
            btn_s1_q <= {BTND, BTNR, BTNL, BTNU, BTNC};
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
            pend_q   <= pend_d;
        end
    end

    // ---------------- display scan ----------------
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'b0000001;  4'h1: hex_seg = 7'b1001111;
            4'h2: hex_seg = 7'b0010010;  4'h3: hex_seg = 7'b0000110;
            4'h4: hex_seg = 7'b1001100;  4'h5: hex_seg = 7'b0100100;
            4'h6: hex_seg = 7'b0100000;  4'h7: hex_seg = 7'b0001111;
            4'h8: hex_seg = 7'b0000000;  4'h9: hex_seg = 7'b0000100;
            4'hA: hex_seg = 7'b0001000;  4'hB: hex_seg = 7'b1100000;
            4'hC: hex_seg = 7'b0110001;  4'hD: hex_seg = 7'b1000010;
            4'hE: hex_seg = 7'b0110000;  default: hex_seg = 7'b0111000;
        endcase
    endfunction

    logic [SCAN_BITS+2:0] scan_q, scan_d;
    logic [2:0]           digit;
    logic [31:0]          disp_val, disp_shift;
    logic [7:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;

    assign digit    = scan_q[SCAN_BITS+2 -: 3];
    assign disp_val = {3'b000, pend_q, 4'h0, ps_q, count_q};

    always_comb begin
        scan_d     = scan_q + 1'b1;
        disp_shift = disp_val >> {digit, 2'b00};
        an_d       = ~(8'd1 << digit);
        seg_d      = hex_seg(disp_shift[3:0]);
    end

    // Registered so that reset blanks the segments and selects digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
            an_q   <= 8'hFE;
            seg_q  <= 7'h7F;
        end else begin
            scan_q <= scan_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign AN                           = an_q;
    assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
    assign DP                           = 1'b1;

    assign irq_pending  = pend_q;
    assign dbg_state    = ps_q;
    assign dbg_count    = count_q;
    assign dbg_rx_state = rx_st_q;
    assign dbg_tx_busy  = tx_busy_q;
endmodule

// File: tb/tb_cpu_top_boot.sv
module tb_cpu_top_boot;
    localparam int CLK_HZ    = 80;
    localparam int BAUD      = 10;
    localparam int BIT_CYC   = CLK_HZ / BAUD;
    localparam int SCAN_BITS = 3;

    logic        clk, rst_n;
    logic        btnc, btnu, btnl, btnr, btnd;
    logic        uart_in, uart_out;
    logic [7:0]  an;
    logic        ca, cb, cc, cd, ce, cf, cg, dp;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [4:0]  irq_pending;
    logic [3:0]  dbg_state;
    logic [15:0] dbg_count;
    logic [2:0]  dbg_rx_state;
    logic        dbg_tx_busy;

    cpu_top_boot #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .IMEM_WORDS(256), .SCAN_BITS(SCAN_BITS)
    ) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n),
        .BTNC(btnc), .BTNU(btnu), .BTNL(btnl), .BTNR(btnr), .BTND(btnd),
        .UART_TXD_IN(uart_in), .UART_RXD_OUT(uart_out),
        .AN(an), .CA(ca), .CB(cb), .CC(cc), .CD(cd), .CE(ce), .CF(cf), .CG(cg), .DP(dp),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .irq_pending(irq_pending),
        .dbg_state(dbg_state), .dbg_count(dbg_count),
        .dbg_rx_state(dbg_rx_state), .dbg_tx_busy(dbg_tx_busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] prog [24];
    logic [6:0]  seg_tab [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- serial monitor on the DUT output ----------------
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_out);
            repeat (BIT_CYC / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT_CYC) @(negedge clk);
                b[i] = uart_out;
            end
            got_q.push_back(b);
        end
    end

    // ---------------- drivers ----------------
    task automatic send_bit(input logic v);
        uart_in = v;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    // Every byte ends with a low stop bit followed by one idle-high bit.
    task automatic send_byte(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic send_head(input logic [7:0] stag, input logic [31:0] len);
        send_word(32'hF0F0_F0F0);
        send_byte(stag);
        repeat (3) send_byte(8'h00);
        send_word(len);
    endtask

    task automatic send_frame(input logic [7:0] stag, input int nwords, input logic [31:0] mask);
        send_head(stag, 32'(nwords));
        for (int i = 0; i < nwords; i++) send_word(prog[i] ^ mask);
        send_word(32'h0F0F_0F0F);
        send_byte(8'hC2);
        repeat (3) send_byte(8'h00);
    endtask

    task automatic expect_tx(input string tag);
        int         t = 0;
        logic [7:0] g;
        logic [7:0] e;
        while (got_q.size() == 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        e = exp_q.pop_front();
        g = (got_q.size() == 0) ? 8'hxx : got_q.pop_front();
        check(tag, {24'h0, g}, {24'h0, e});
    endtask

    task automatic check_imem(input string tag, input int a, input logic [31:0] e);
        imem_addr = 8'(a);
        @(negedge clk);
        check(tag, imem_rdata, e);
    endtask

    // Collects the 8 scanned digits back into a 32-bit value.
    task automatic read_disp(output logic [31:0] v);
        v = '0;
        for (int i = 0; i < 8; i++) begin
            int         t = 0;
            logic [7:0] an_exp;
            logic [3:0] nib;
            an_exp = ~(8'd1 << i);
            while (an !== an_exp && t < 300) begin
                @(negedge clk);
                t++;
            end
            nib = 4'bxxxx;
            for (int k = 0; k < 16; k++)
                if (seg_tab[k] === {ca, cb, cc, cd, ce, cf, cg}) nib = k[3:0];
            v[i*4 +: 4] = nib;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] dv;
        prog = '{32'h27BDFFF0, 32'hAFBE000C, 32'h03A0F025, 32'h24020005,
                 32'hAFC20000, 32'h8FC20000, 32'h00000000, 32'h24420001,
                 32'hAFC20000, 32'h8FC30000, 32'h2402000A, 32'h1462FFF9,
                 32'h00000000, 32'h8FC20000, 32'h03C0E825, 32'h8FBE000C,
                 32'h27BD0010, 32'h00000000, 32'h00000000, 32'h00000000,
                 32'h00000000, 32'h03E00008, 32'h00000000, 32'h00000000};
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        rst_n = 1'b0;
        uart_in = 1'b1;
        {btnc, btnu, btnl, btnr, btnd} = '0;
        imem_addr = '0;

        // reset values
        repeat (10) @(negedge clk);
        check("rst_tx_line", {31'h0, uart_out}, 32'd1);
        check("rst_an", {24'h0, an}, 32'hFE);
        check("rst_segs", {25'h0, ca, cb, cc, cd, ce, cf, cg}, 32'h7F);
        check("rst_dp", {31'h0, dp}, 32'd1);
        check("rst_state", {28'h0, dbg_state}, 32'h0);
        check("rst_count", {16'h0, dbg_count}, 32'h0);
        check("rst_pending", {27'h0, irq_pending}, 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        read_disp(dv);
        check("disp_idle", dv, 32'h0000_0000);

        // full 24-word load
        exp_q.push_back(8'h18);
        send_frame(8'hC2, 24, 32'h0);
        expect_tx("tx_done_24");
        check("load_state", {28'h0, dbg_state}, 32'h0);
        check("load_count", {16'h0, dbg_count}, 32'h18);
        check_imem("imem0", 0, 32'h27BDFFF0);
        check_imem("imem1", 1, 32'hAFBE000C);
        check_imem("imem21", 21, 32'h03E00008);
        check_imem("imem23", 23, 32'h00000000);
        read_disp(dv);
        check("disp_loaded", dv, 32'h0000_0018);

        // bad start tag, different payload must not land in memory
        exp_q.push_back(8'hEE);
        send_frame(8'hC3, 24, 32'hA5A5_A5A5);
        expect_tx("tx_bad_stag");
        check("stag_state", {28'h0, dbg_state}, 32'h0);
        check("stag_count", {16'h0, dbg_count}, 32'h0);
        check_imem("stag_imem0", 0, 32'h27BDFFF0);
        check_imem("stag_imem5", 5, 32'h8FC20000);

        // length beyond memory depth
        exp_q.push_back(8'hEE);
        send_head(8'hC2, 32'h0000_0101);
        check("len_ovf_state", {28'h0, dbg_state}, 32'h0);
        expect_tx("tx_len_ovf");
        check("len_ovf_count", {16'h0, dbg_count}, 32'h0);

        // button interrupts latch, SYNC clears them
        @(negedge clk);
        btnc = 1'b1;
        btnd = 1'b1;
        repeat (5) @(negedge clk);
        btnc = 1'b0;
        btnd = 1'b0;
        repeat (5) @(negedge clk);
        check("irq_pending", {27'h0, irq_pending}, 32'h11);
        read_disp(dv);
        check("disp_irq", dv, 32'h1100_0000);
        send_word(32'hF0F0_F0F0);
        check("irq_cleared", {27'h0, irq_pending}, 32'h0);
        check("sync_state", {28'h0, dbg_state}, 32'h1);
        read_disp(dv);
        check("disp_stag", dv, 32'h0001_0000);
        exp_q.push_back(8'hEE);
        send_byte(8'h00);
        check("stag_err_state", {28'h0, dbg_state}, 32'h0);
        expect_tx("tx_stag_00");

        // reset in the middle of DATA, then reload
        send_head(8'hC2, 32'd24);
        for (int i = 0; i < 5; i++) send_word(prog[i] ^ 32'h0000_FFFF);
        check("mid_state", {28'h0, dbg_state}, 32'h4);
        check("mid_count", {16'h0, dbg_count}, 32'h5);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_rst_state", {28'h0, dbg_state}, 32'h0);
        check("mid_rst_count", {16'h0, dbg_count}, 32'h0);
        rst_n = 1'b1;
        repeat (30 * BIT_CYC) @(negedge clk);
        check("no_tx_after_rst", 32'(got_q.size()), 32'd0);
        check_imem("partial_imem2", 2, 32'h03A00FDA);
        exp_q.push_back(8'h18);
        send_frame(8'hC2, 24, 32'h0);
        expect_tx("tx_reload");
        check("reload_count", {16'h0, dbg_count}, 32'h18);
        check_imem("reload_imem0", 0, 32'h27BDFFF0);
        check_imem("reload_imem2", 2, 32'h03A0F025);
        check_imem("reload_imem23", 23, 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/cpu_top_boot.md
Name: cpu_top_boot

Overview:
- FPGA top shell for the Nexys4-class board.
- Receives a program image over UART (9600 8N1) through a framed boot protocol and writes it into an internal instruction memory.
- Acknowledges each frame with one UART byte.
- Latches button interrupt requests and drives the 8-digit seven-segment display with status.
- The processor core attaches to the instruction memory and interrupt-pending register. The core is outside this block.

Parameters:
CLK_HZ, 100_000_000, system clock frequency
BAUD, 9600, UART bit rate; bit period BIT_CYC = CLK_HZ/BAUD (10416 cycles)
IMEM_WORDS, 256, instruction memory depth in 32-bit words
SCAN_BITS, 17, display digit dwell = 2^SCAN_BITS cycles

Ports:
CLK100MHZ  in  1  system clock, rising edge
CPU_RESETN  in  1  reset; asynchronous assert, active-low
BTNC, BTNU, BTNL, BTNR, BTND  in  1 each  interrupt request buttons INT1..INT5, asynchronous
UART_TXD_IN  in  1  serial data from host, idle high
UART_RXD_OUT  out  1  serial data to host, idle high
AN  out  8  digit enables, active-low, AN[i] = digit i
CA, CB, CC, CD, CE, CF, CG  out  1 each  segments a..g, active-low
DP  out  1  decimal point, active-low, held 1 (off)

Behaviour:
- Reset values while CPU_RESETN=0:
  - UART_RXD_OUT=1, AN=8'hFE, all segments 1, DP=1.
  - FSM in HUNT, word count 0, pending 0, imem contents unchanged.
- UART RX:
  - Double-flop synchronize UART_TXD_IN.
  - A falling edge in IDLE starts a byte; recheck low at BIT_CYC/2, else abort.
  - Sample bits 0..7 LSB first at 1.5, 2.5 … 8.5 bit periods; deliver byte as a 1-cycle strobe after bit 7.
  - Stop bit is NOT checked; a low stop bit is legal.
  - The receiver re-arms only after the line has been seen high, so a low stop bit never triggers a false start.
- Frame format, all multi-byte fields big-endian:
  - SYNC: F0 F0 F0 F0.
  - TAG: C2, then 3 pad bytes (ignored).
  - LEN: 32-bit N.
  - DATA: N words.
  - END: 0F 0F 0F 0F.
  - TAG: C2, then 3 pad bytes.
- Parser states: HUNT, STAG, SPAD, LEN, DATA, END, ETAG, EPAD, DONE, ERR.
  - HUNT: 32-bit shift register; on F0F0F0F0 go to STAG, clear word count and pending.
  - STAG: C2 goes to SPAD; any other byte goes to ERR.
  - SPAD: 3 bytes, then LEN.
  - LEN: 4 bytes, then DATA. If N=0, go straight to END.
  - DATA: assemble 4 bytes into a word, write imem[count], count++; after N words go to END.
  - END: must be exactly 0F0F0F0F, else ERR.
  - ETAG: C2, else ERR.
  - EPAD: 3 bytes, then DONE.
- N > IMEM_WORDS: go to ERR when LEN completes.
- DONE: queue TX byte = count[7:0], then return to HUNT. The loaded image remains valid.
- ERR: queue TX byte 8'hEE, then return to HUNT. Partially written words remain.
- A new SYNC while in HUNT restarts the frame.
- UART TX:
  - Standard 8N1, LSB first, BIT_CYC per bit, one high stop bit.
  - One-byte queue; a new request while busy overwrites the queued byte.
- Interrupts:
  - Each button is 2-flop synchronized.
  - A rising edge sets pending[i] (INT1=bit0 … INT5=bit4).
  - Pending bits clear only on reset or a new SYNC.
  - Simultaneous edges set all affected bits.
- Display value (32 bits):
  - digits 7..6 = {3'b0, pending}
  - digits 5..4 = state code: HUNT=00, STAG=01, SPAD=02, LEN=03, DATA=04, END=05, ETAG=06, EPAD=07, DONE=0D, ERR=0E
  - digits 3..0 = count[15:0]
- Display scan:
  - A free-running counter advances the digit index every 2^SCAN_BITS cycles, digit 0 first, wrapping 7 to 0.
  - Exactly one AN bit is low at a time.
  - Segments use standard hex 0-F patterns, active-low; e.g. 0 → CA..CG = 0000001.

Test Plan:
- Reset held 10 cycles → UART_RXD_OUT=1, AN=FE, DP=1, state code 00, count 0.
- Send the 24-word frame (F0F0F0F0 C2 000000, N=00000018, words 27BDFFF0, AFBE000C … 03E00008, 00000000, 00000000, then 0F0F0F0F C2 000000), each byte with a low stop bit → imem[0]=27BDFFF0, imem[23]=00000000, count=0x18, TX byte 0x18.
- Same frame but STAG byte 0xC3 → TX 0xEE, imem not written, back in HUNT.
- LEN=0x00000101 (>256) → TX 0xEE immediately after LEN.
- Pulse BTNC and BTND → pending=5'b10001, digits 7..6 show 11; a subsequent SYNC clears them to 00.
- Assert CPU_RESETN low mid-DATA → state HUNT, count 0, no TX byte; a full resend then loads correctly.
